// File: rtl/z80fi_insn_capture.sv
// z80fi_insn_capture
//   Collects the opcode/operand bytes and up to two data-memory reads of one
//   instruction. On retire it emits one registered z80fi packet that the
//   z80fi_insn_spec_* checkers consume.
//
// Parameters
//   MAX_INSN_LEN   bytes captured per instruction (1..4)
//
// Ports
//   clk, reset                        clock; asynchronous active-high reset
//   fetch_valid/addr/data             one instruction byte fetched this cycle
//   rd_valid/addr/data                one data-memory read completed this cycle
//   retire                            current instruction completes this cycle
//   z80fi_valid                       one-cycle packet strobe
//   z80fi_pc/insn/insn_len            first-byte address, bytes (LSB first), count
//   z80fi_mem_rd_count                data reads captured (0..2)
//   z80fi_mem_raddr/rdata(2)          first/second read, 0 when absent
//   capture_err                       sticky: overflow or empty retire
//
// Build option
//   Z80FI_CAPTURE_ASSERT_EN  adds immediate assertions that capture_err never
//                            rises and that every packet has a nonzero length.
module z80fi_insn_capture #(
    parameter int MAX_INSN_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [15:0] fetch_addr,
    input  logic [7:0]  fetch_data,
    input  logic        rd_valid,
    input  logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        retire,
    output logic        z80fi_valid,
    output logic [15:0] z80fi_pc,
    output logic [31:0] z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [1:0]  z80fi_mem_rd_count,
    output logic [15:0] z80fi_mem_raddr,
    output logic [7:0]  z80fi_mem_rdata,
    output logic [15:0] z80fi_mem_raddr2,
    output logic [7:0]  z80fi_mem_rdata2,
    output logic        capture_err
);

    localparam logic [2:0] MAX_LEN = 3'(MAX_INSN_LEN);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t      state_q, state_n;
    logic [31:0] insn_q, insn_n, insn_e;
    logic [2:0]  len_q, len_n, len_e;
    logic [15:0] pc_q, pc_n, pc_e;
    logic [1:0]  rcnt_q, rcnt_n, rcnt_e;
    logic [15:0] ra1_q, ra1_n, ra1_e, ra2_q, ra2_n, ra2_e;
    logic [7:0]  rd1_q, rd1_n, rd1_e, rd2_q, rd2_n, rd2_e;
    logic        err_q, err_n;
    logic        launch;

    // *_e = accumulator contents including this cycle's fetch/read, which
    // belong to the retiring instruction when retire is also asserted.
    always_comb begin
        insn_e  = insn_q;
        len_e   = len_q;
        pc_e    = pc_q;
        rcnt_e  = rcnt_q;
        ra1_e   = ra1_q;
        rd1_e   = rd1_q;
        ra2_e   = ra2_q;
        rd2_e   = rd2_q;
        err_n   = err_q;
        state_n = state_q;
        launch  = 1'b0;

        if (fetch_valid) begin
            if (state_q == IDLE) begin
                insn_e  = {24'h0, fetch_data};
                len_e   = 3'd1;
                pc_e    = fetch_addr;
                state_n = COLLECT;
            end else if (len_q < MAX_LEN) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (len_q == 3'(k)) insn_e[8*k +: 8] = fetch_data;
                end
                len_e = len_q + 3'd1;
            end else begin
                err_n = 1'b1;
            end
        end

        if (rd_valid) begin
            case (rcnt_q)
                2'd0: begin ra1_e = rd_addr; rd1_e = rd_data; rcnt_e = 2'd1; end
                2'd1: begin ra2_e = rd_addr; rd2_e = rd_data; rcnt_e = 2'd2; end
                default: err_n = 1'b1;
            endcase
        end

        insn_n = insn_e;
        len_n  = len_e;
        pc_n   = pc_e;
        rcnt_n = rcnt_e;
        ra1_n  = ra1_e;
        rd1_n  = rd1_e;
        ra2_n  = ra2_e;
        rd2_n  = rd2_e;

        if (retire) begin
            if (len_e != 3'd0) begin
                launch  = 1'b1;
                state_n = IDLE;
                insn_n  = '0;
                len_n   = '0;
                pc_n    = '0;
                rcnt_n  = '0;
                ra1_n   = '0;
                rd1_n   = '0;
                ra2_n   = '0;
                rd2_n   = '0;
            end else begin
                // Empty retire: reads seen in IDLE stay held for the next insn.
                err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            insn_q  <= '0;
            len_q   <= '0;
            pc_q    <= '0;
            rcnt_q  <= '0;
            ra1_q   <= '0;
            rd1_q   <= '0;
            ra2_q   <= '0;
            rd2_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            insn_q  <= insn_n;
            len_q   <= len_n;
            pc_q    <= pc_n;
            rcnt_q  <= rcnt_n;
            ra1_q   <= ra1_n;
            rd1_q   <= rd1_n;
            ra2_q   <= ra2_n;
            rd2_q   <= rd2_n;
            err_q   <= err_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z80fi_valid        <= 1'b0;
            z80fi_pc           <= '0;
            z80fi_insn         <= '0;
            z80fi_insn_len     <= '0;
            z80fi_mem_rd_count <= '0;
            z80fi_mem_raddr    <= '0;
            z80fi_mem_rdata    <= '0;
            z80fi_mem_raddr2   <= '0;
            z80fi_mem_rdata2   <= '0;
        end else begin
            z80fi_valid <= launch;
            if (launch) begin
                z80fi_pc           <= pc_e;
                z80fi_insn         <= insn_e;
                z80fi_insn_len     <= len_e;
                z80fi_mem_rd_count <= rcnt_e;
                z80fi_mem_raddr    <= ra1_e;
                z80fi_mem_rdata    <= rd1_e;
                z80fi_mem_raddr2   <= ra2_e;
                z80fi_mem_rdata2   <= rd2_e;
            end
        end
    end

    assign capture_err = err_q;

`ifdef Z80FI_CAPTURE_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(err_n && !err_q));
            assert (!z80fi_valid || (z80fi_insn_len != 3'd0));
        end
    end
`endif

endmodule

// File: tb/tb_z80fi_insn_capture.sv
module tb_z80fi_insn_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic [7:0]  fetch_data = '0;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_addr = '0;
    logic [7:0]  rd_data = '0;
    logic        retire = 1'b0;
    logic        z80fi_valid;
    logic [15:0] z80fi_pc;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [1:0]  z80fi_mem_rd_count;
    logic [15:0] z80fi_mem_raddr;
    logic [7:0]  z80fi_mem_rdata;
    logic [15:0] z80fi_mem_raddr2;
    logic [7:0]  z80fi_mem_rdata2;
    logic        capture_err;

    int errors = 0;
    int checks = 0;

    z80fi_insn_capture #(.MAX_INSN_LEN(4)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .retire(retire),
        .z80fi_valid(z80fi_valid), .z80fi_pc(z80fi_pc), .z80fi_insn(z80fi_insn),
        .z80fi_insn_len(z80fi_insn_len), .z80fi_mem_rd_count(z80fi_mem_rd_count),
        .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_rdata(z80fi_mem_rdata),
        .z80fi_mem_raddr2(z80fi_mem_raddr2), .z80fi_mem_rdata2(z80fi_mem_rdata2),
        .capture_err(capture_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pkt(input string tag, input logic v, input logic [15:0] pc,
                       input logic [31:0] insn, input logic [2:0] len, input logic [1:0] cnt,
                       input logic [15:0] ra, input logic [7:0] rd,
                       input logic [15:0] ra2, input logic [7:0] rd2, input logic err);
        chk({tag, ".valid"}, 32'(z80fi_valid), 32'(v));
        chk({tag, ".pc"}, 32'(z80fi_pc), 32'(pc));
        chk({tag, ".insn"}, z80fi_insn, insn);
        chk({tag, ".len"}, 32'(z80fi_insn_len), 32'(len));
        chk({tag, ".rdcnt"}, 32'(z80fi_mem_rd_count), 32'(cnt));
        chk({tag, ".raddr"}, 32'(z80fi_mem_raddr), 32'(ra));
        chk({tag, ".rdata"}, 32'(z80fi_mem_rdata), 32'(rd));
        chk({tag, ".raddr2"}, 32'(z80fi_mem_raddr2), 32'(ra2));
        chk({tag, ".rdata2"}, 32'(z80fi_mem_rdata2), 32'(rd2));
        chk({tag, ".err"}, 32'(capture_err), 32'(err));
    endtask

    // One clock: inputs set beforehand are sampled at the edge; outputs read #1 later.
    task automatic tick;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        rd_valid    = 1'b0;
        retire      = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a, input logic [7:0] d);
        fetch_valid = 1'b1; fetch_addr = a; fetch_data = d;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] d);
        rd_valid = 1'b1; rd_addr = a; rd_data = d;
    endtask

    initial begin
        // Reset state
        #12;
        pkt("reset", 0, 16'h0, 32'h0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0, 0);
        @(posedge clk); #1 reset = 1'b0;

        // 1: JP (HL) with two reads
        fetch(16'h1234, 8'hE9); tick;
        rd(16'h4000, 8'h78); tick;
        rd(16'h4001, 8'h56); retire = 1'b1; tick;
        pkt("t1", 1, 16'h1234, 32'h000000E9, 1, 2, 16'h4000, 8'h78, 16'h4001, 8'h56, 0);
        tick;
        pkt("t1hold", 0, 16'h1234, 32'h000000E9, 1, 2, 16'h4000, 8'h78, 16'h4001, 8'h56, 0);

        // 2: JP (IX), second byte fetched in the retire cycle
        fetch(16'h2000, 8'hDD); tick;
        fetch(16'h2001, 8'hE9); retire = 1'b1; tick;
        pkt("t2", 1, 16'h2000, 32'h0000E9DD, 2, 0, 16'h0, 8'h0, 16'h0, 8'h0, 0);

        // 3: five bytes and three reads -> saturation and err
        fetch(16'h3000, 8'h11); tick;
        fetch(16'h3001, 8'h22); rd(16'h5000, 8'hA1); tick;
        fetch(16'h3002, 8'h33); rd(16'h5001, 8'hB2); tick;
        fetch(16'h3003, 8'h44); rd(16'h5002, 8'hC3); tick;
        fetch(16'h3004, 8'h55); tick;
        retire = 1'b1; tick;
        pkt("t3", 1, 16'h3000, 32'h44332211, 4, 2, 16'h5000, 8'hA1, 16'h5001, 8'hB2, 1);

        // 4: async reset mid-COLLECT
        fetch(16'h4000, 8'hAA); tick;
        fetch(16'h4001, 8'hBB); tick;
        #2 reset = 1'b1;
        #1;
        pkt("t4rst", 0, 16'h0, 32'h0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0, 0);
        @(posedge clk); #1 reset = 1'b0;
        fetch(16'h0000, 8'h00); tick;
        retire = 1'b1; tick;
        pkt("t4", 1, 16'h0000, 32'h0, 1, 0, 16'h0, 8'h0, 16'h0, 8'h0, 0);

        // 5: back-to-back
        fetch(16'h0100, 8'hE9); retire = 1'b1; tick;
        pkt("t5a", 1, 16'h0100, 32'h000000E9, 1, 0, 16'h0, 8'h0, 16'h0, 8'h0, 0);
        fetch(16'h0200, 8'hC3); tick;
        pkt("t5gap", 0, 16'h0100, 32'h000000E9, 1, 0, 16'h0, 8'h0, 16'h0, 8'h0, 0);
        retire = 1'b1; tick;
        pkt("t5b", 1, 16'h0200, 32'h000000C3, 1, 0, 16'h0, 8'h0, 16'h0, 8'h0, 0);

        // 6: empty retire right after reset
        reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
        retire = 1'b1; tick;
        chk("t6.valid", 32'(z80fi_valid), 32'h0);
        chk("t6.err", 32'(capture_err), 32'h1);
        tick;
        chk("t6.sticky", 32'(capture_err), 32'h1);

        // Read in IDLE carries into the next instruction
        rd(16'h6000, 8'h99); tick;
        fetch(16'h7000, 8'h00); tick;
        retire = 1'b1; tick;
        pkt("idle_rd", 1, 16'h7000, 32'h0, 1, 1, 16'h6000, 8'h99, 16'h0, 8'h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
